// File: rtl/regfile_bist_pkg.sv
// Shared types, sizes and the test pattern for the register-file BIST.
package regfile_bist_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 8;
  localparam int ERR_W    = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ_ADDR = 3'd2,
    READ_CHK  = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Pass 0 writes seed+idx (mod 256); pass 1 writes its bitwise inverse.
  function automatic logic [DATA_W-1:0] bist_pattern(
    input logic [DATA_W-1:0] seed,
    input logic [ADDR_W-1:0] idx,
    input logic              pass
  );
    logic [DATA_W-1:0] base;
    base = seed + {{(DATA_W-ADDR_W){1'b0}}, idx};
    return pass ? ~base : base;
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Register-file port bundle: write port plus two combinational read ports.
interface regfile_bist_if;
  import regfile_bist_pkg::*;

  logic [ADDR_W-1:0] Addr_WR;
  logic              WR;
  logic [DATA_W-1:0] DIN;
  logic [ADDR_W-1:0] Addr_A;
  logic [ADDR_W-1:0] Addr_B;
  logic [DATA_W-1:0] Out_A;
  logic [DATA_W-1:0] Out_B;

  // The BIST drives addresses and write data, the register file answers.
  modport master (
    output Addr_WR, WR, DIN, Addr_A, Addr_B,
    input  Out_A, Out_B
  );

  modport slave (
    input  Addr_WR, WR, DIN, Addr_A, Addr_B,
    output Out_A, Out_B
  );
endinterface

// File: rtl/regfile_bist.sv
// Register-file BIST initiator: two write/readback passes (pattern, then
// inverse), reports pass/fail, mismatch count and first failing address.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for Start; all bus outputs 0
//   WRITE     | writing register idx with the current pass pattern
//   READ_ADDR | presenting pair addresses 2k / 2k+1 on ports A / B
//   READ_CHK  | addresses held; comparing Out_A / Out_B, accumulating errors
//   DONE      | one-cycle Done pulse; Pass/Err_Count final
module regfile_bist
  import regfile_bist_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [DATA_W-1:0]     Seed,
  regfile_bist_if.master        rf,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Pass,
  output logic [ERR_W-1:0]      Err_Count,
  output logic [ADDR_W-1:0]     First_Err_Addr
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                phase_q, phase_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                pass_q, pass_d;

  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_wr_q, addr_wr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                mis_a, mis_b;
  logic [ADDR_W-1:0]   addr_even, addr_odd;

  // Next-state, counters and result accumulation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    seed_d    = seed_q;
    err_d     = err_q;
    first_d   = first_q;
    pass_d    = pass_q;
    mis_a     = 1'b0;
    mis_b     = 1'b0;
    addr_even = {idx_q[2:0], 1'b0};
    addr_odd  = {idx_q[2:0], 1'b1};

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = WRITE;
          idx_d   = '0;
          phase_d = 1'b0;
          seed_d  = Seed;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      WRITE: begin
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = READ_ADDR;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      READ_ADDR: begin
        state_d = READ_CHK;
      end
      READ_CHK: begin
        mis_a = (rf.Out_A != bist_pattern(seed_q, addr_even, phase_q));
        mis_b = (rf.Out_B != bist_pattern(seed_q, addr_odd, phase_q));
        err_d = err_q + ERR_W'(mis_a) + ERR_W'(mis_b);
        // Port A wins a tie because its address is the lower of the pair.
        if ((err_q == '0) && (mis_a || mis_b)) begin
          first_d = mis_a ? addr_even : addr_odd;
        end
        if (idx_q == ADDR_W'(NUM_REGS / 2 - 1)) begin
          if (!phase_q) begin
            state_d = WRITE;
            phase_d = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end
        end else begin
          state_d = READ_ADDR;
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and handshake outputs decoded from the upcoming state so they register cleanly.
  always_comb begin
    wr_d      = 1'b0;
    addr_wr_d = '0;
    din_d     = '0;
    addr_a_d  = '0;
    addr_b_d  = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_d)
      WRITE: begin
        wr_d      = 1'b1;
        addr_wr_d = idx_d;
        din_d     = bist_pattern(seed_d, idx_d, phase_d);
        busy_d    = 1'b1;
      end
      READ_ADDR, READ_CHK: begin
        addr_a_d = {idx_d[2:0], 1'b0};
        addr_b_d = {idx_d[2:0], 1'b1};
        busy_d   = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counters and registered outputs; reset abandons any partial test.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      phase_q   <= 1'b0;
      seed_q    <= '0;
      err_q     <= '0;
      first_q   <= '0;
      pass_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_wr_q <= '0;
      din_q     <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      seed_q    <= seed_d;
      err_q     <= err_d;
      first_q   <= first_d;
      pass_q    <= pass_d;
      wr_q      <= wr_d;
      addr_wr_q <= addr_wr_d;
      din_q     <= din_d;
      addr_a_q  <= addr_a_d;
      addr_b_q  <= addr_b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rf.WR          = wr_q;
  assign rf.Addr_WR     = addr_wr_q;
  assign rf.DIN         = din_q;
  assign rf.Addr_A      = addr_a_q;
  assign rf.Addr_B      = addr_b_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Pass           = pass_q;
  assign Err_Count      = err_q;
  assign First_Err_Addr = first_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: behavioural register file with fault injection,
// expected writes/results queued by the stimulus and checked by a monitor.
module tb_regfile_bist;
  import regfile_bist_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Seed  = 8'h00;
  logic       Busy, Done, Pass;
  logic [5:0] Err_Count;
  logic [3:0] First_Err_Addr;

  regfile_bist_if rf ();

  regfile_bist dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Start          (Start),
    .Seed           (Seed),
    .rf             (rf),
    .Busy           (Busy),
    .Done           (Done),
    .Pass           (Pass),
    .Err_Count      (Err_Count),
    .First_Err_Addr (First_Err_Addr)
  );

  always #5 Clock = ~Clock;

  // Register file model: fault 1 = reg 5 bit 3 stuck-at-0, fault 2 = writes to reg 3 land in reg 2.
  logic [7:0] mem [16];
  int         fault = 0;
  logic       clr   = 1'b1;

  always @(posedge Clock) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else if (rf.WR) begin
      if (fault == 2 && rf.Addr_WR == 4'd3) mem[2] <= rf.DIN;
      else mem[rf.Addr_WR] <= rf.DIN;
    end
  end

  assign rf.Out_A = mem[rf.Addr_A] & ((fault == 1 && rf.Addr_A == 4'd5) ? 8'hF7 : 8'hFF);
  assign rf.Out_B = mem[rf.Addr_B] & ((fault == 1 && rf.Addr_B == 4'd5) ? 8'hF7 : 8'hFF);

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct { logic [3:0] addr; logic [7:0] data; } wr_t;
  typedef struct { int cycle; logic pass; logic [5:0] err; logic [3:0] first; } dn_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } dc_t;

  wr_t wq[$];
  dn_t dq[$];
  dc_t dcq[$];

  logic [7:0] wlog [32];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT write and Done against the queues, and drains directed checks.
  always @(negedge Clock) begin
    int  c;
    wr_t w;
    dn_t d;
    dc_t x;
    c = cyc - start_cyc;
    if (!Reset && rf.WR) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write", rf.Addr_WR, rf.DIN);
      end else begin
        w = wq.pop_front();
        check("write_addr", {28'h0, rf.Addr_WR}, {28'h0, w.addr});
        check("write_data", {24'h0, rf.DIN}, {24'h0, w.data});
        check("busy_during_write", {31'h0, Busy}, 32'h1);
        if (c >= 1 && c <= 16) wlog[c-1] = rf.DIN;
        else if (c >= 33 && c <= 48) wlog[c-17] = rf.DIN;
      end
    end
    if (!Reset && Done) begin
      done_cnt++;
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual cycle=%0d required=no done", c);
      end else begin
        d = dq.pop_front();
        check("done_cycle", c, d.cycle);
        check("done_pass", {31'h0, Pass}, {31'h0, d.pass});
        check("done_err_count", {26'h0, Err_Count}, {26'h0, d.err});
        check("done_busy_low", {31'h0, Busy}, 32'h0);
        if (d.err != 6'd0) check("first_err_addr", {28'h0, First_Err_Addr}, {28'h0, d.first});
      end
    end
    while (dcq.size() > 0) begin
      x = dcq.pop_front();
      check(x.name, x.act, x.exp);
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    dc_t x;
    x.name = name;
    x.act  = act;
    x.exp  = exp;
    dcq.push_back(x);
  endtask

  task automatic push_writes(input logic [7:0] seed, input int n);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.addr = 4'(k % 16);
      w.data = (k < 16) ? (seed + 8'(k)) : ~(seed + 8'(k - 16));
      wq.push_back(w);
    end
  endtask

  task automatic push_done(input logic p, input logic [5:0] e, input logic [3:0] f);
    dn_t d;
    d.cycle = 65;
    d.pass  = p;
    d.err   = e;
    d.first = f;
    dq.push_back(d);
  endtask

  // Drives a one-cycle Start; returns at the negedge of cycle 1.
  task automatic start_test(input logic [7:0] seed);
    @(negedge Clock);
    start_cyc = cyc;
    Start = 1'b1;
    Seed  = seed;
    @(negedge Clock);
    Start = 1'b0;
    Seed  = ~seed;
    expect_eq("busy_cycle1", {31'h0, Busy}, 32'h1);
  endtask

  task automatic wait_done(input logic exp_pass, input logic [5:0] exp_err);
    int prev;
    int n;
    prev = done_cnt;
    n = 0;
    while (done_cnt == prev && n < 120) begin
      @(negedge Clock);
      n++;
    end
    expect_eq("done_seen", done_cnt - prev, 1);
    repeat (3) @(negedge Clock);
    expect_eq("pass_held", {31'h0, Pass}, {31'h0, exp_pass});
    expect_eq("err_held", {26'h0, Err_Count}, {26'h0, exp_err});
  endtask

  task automatic clear_rf(input int f);
    @(negedge Clock);
    fault = f;
    clr = 1'b1;
    @(negedge Clock);
    clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    expect_eq("rst_wr", {31'h0, rf.WR}, 32'h0);
    expect_eq("rst_busy", {31'h0, Busy}, 32'h0);
    expect_eq("rst_done", {31'h0, Done}, 32'h0);
    expect_eq("rst_pass", {31'h0, Pass}, 32'h0);
    expect_eq("rst_err", {26'h0, Err_Count}, 32'h0);
    expect_eq("rst_addr", {16'h0, rf.Addr_WR, rf.Addr_A, rf.Addr_B, First_Err_Addr}, 32'h0);
    expect_eq("rst_din", {24'h0, rf.DIN}, 32'h0);
    Reset = 1'b0;
    clr   = 1'b0;

    // Healthy, seed 00
    clear_rf(0);
    push_writes(8'h00, 32);
    push_done(1'b1, 6'd0, 4'd0);
    start_test(8'h00);
    wait_done(1'b1, 6'd0);
    expect_eq("s00_w0", {24'h0, wlog[0]}, 32'h00);
    expect_eq("s00_w15", {24'h0, wlog[15]}, 32'h0F);
    expect_eq("s00_inv0", {24'h0, wlog[16]}, 32'hFF);
    expect_eq("s00_inv15", {24'h0, wlog[31]}, 32'hF0);

    // Seed F8 wraps mod 256
    clear_rf(0);
    push_writes(8'hF8, 32);
    push_done(1'b1, 6'd0, 4'd0);
    start_test(8'hF8);
    wait_done(1'b1, 6'd0);
    expect_eq("sF8_reg8", {24'h0, wlog[8]}, 32'h00);
    expect_eq("sF8_reg15", {24'h0, wlog[15]}, 32'h07);
    expect_eq("sF8_inv0", {24'h0, wlog[16]}, 32'h07);

    // Reg 5 bit 3 stuck-at-0
    clear_rf(1);
    push_writes(8'h00, 32);
    push_done(1'b0, 6'd1, 4'd5);
    start_test(8'h00);
    wait_done(1'b0, 6'd1);
    expect_eq("stuck_first", {28'h0, First_Err_Addr}, 32'h5);

    // Start pulses at cycles 10 and 40 and during DONE are ignored
    clear_rf(0);
    push_writes(8'h3C, 32);
    push_done(1'b1, 6'd0, 4'd0);
    begin
      int prev;
      prev = done_cnt;
      start_test(8'h3C);
      for (int c = 2; c <= 68; c++) begin
        @(negedge Clock);
        Start = (c == 10 || c == 40 || c == 65);
        Seed  = 8'hA5;
        if (c == 66) begin
          expect_eq("start_in_done_busy", {31'h0, Busy}, 32'h0);
          expect_eq("start_in_done_wr", {31'h0, rf.WR}, 32'h0);
        end
      end
      Start = 1'b0;
      expect_eq("single_done", done_cnt - prev, 1);
      expect_eq("restart_pass", {31'h0, Pass}, 32'h1);
    end

    // Reset in cycle 20 abandons the test; a fresh Start completes normally
    clear_rf(0);
    push_writes(8'h77, 16);
    start_test(8'h77);
    for (int c = 2; c <= 21; c++) begin
      @(negedge Clock);
      if (c == 20) Reset = 1'b1;
      if (c == 21) begin
        expect_eq("rst20_wr", {31'h0, rf.WR}, 32'h0);
        expect_eq("rst20_busy", {31'h0, Busy}, 32'h0);
        expect_eq("rst20_status", {25'h0, Pass, Err_Count}, 32'h0);
        expect_eq("rst20_first", {28'h0, First_Err_Addr}, 32'h0);
        expect_eq("rst20_addr", {24'h0, rf.Addr_A, rf.Addr_B}, 32'h0);
        Reset = 1'b0;
      end
    end
    expect_eq("rst20_writes_drained", wq.size(), 0);
    push_writes(8'h55, 32);
    push_done(1'b1, 6'd0, 4'd0);
    start_test(8'h55);
    wait_done(1'b1, 6'd0);

    // Writes to reg 3 alias into reg 2
    clear_rf(2);
    push_writes(8'h10, 32);
    push_done(1'b0, 6'd4, 4'd2);
    start_test(8'h10);
    wait_done(1'b0, 6'd4);
    expect_eq("alias_first", {28'h0, First_Err_Addr}, 32'h2);

    @(negedge Clock);
    expect_eq("writes_all_seen", wq.size(), 0);
    expect_eq("dones_all_seen", dq.size(), 0);
    repeat (3) @(negedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
